// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared types, mode presets and helpers for the VGA timing path.
// Revision    : 1.0 - initial release
// ============================================================================

package vga_pkg;

    localparam int MAX_PIX_LAT = 8;

    // One pixel's worth of sync/enable, kept together so delay stages stay aligned.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } vga_sync_t;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit hs_pol;
        bit vs_pol;
    } vga_mode_t;

    localparam vga_mode_t c_mode_640x480_60 = '{
        h_active: 640,  h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480,  v_fp: 10, v_sync: 2,   v_bp: 33,
        hs_pol:   1'b0, vs_pol: 1'b0
    };

    localparam vga_mode_t c_mode_800x600_60 = '{
        h_active: 800,  h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600,  v_fp: 1,  v_sync: 4,   v_bp: 23,
        hs_pol:   1'b1, vs_pol: 1'b1
    };

    localparam vga_mode_t c_mode_1280x1024_60 = '{
        h_active: 1280, h_fp: 48, h_sync: 112, h_bp: 248,
        v_active: 1024, v_fp: 1,  v_sync: 3,   v_bp: 38,
        hs_pol:   1'b1, vs_pol: 1'b1
    };

    function automatic int mode_h_total(input vga_mode_t m);
        return m.h_active + m.h_fp + m.h_sync + m.h_bp;
    endfunction

    function automatic int mode_v_total(input vga_mode_t m);
        return m.v_active + m.v_fp + m.v_sync + m.v_bp;
    endfunction

    // True when a counter of the given width can reach every position 0..total-1.
    function automatic bit cnt_fits(input int total, input int width);
        return (total >= 1) && (total <= (1 << width));
    endfunction

endpackage : vga_pkg

`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_delay_line
// Description : Clock-enabled shift register with a programmable reset value.
// Revision    : 1.0 - initial release
// ============================================================================

module vga_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    if (DEPTH == 0) begin : g_bypass
        // Zero latency: the register-free path leaves the control inputs idle.
        logic w_unused_bypass;
        assign w_unused_bypass = ^{clk, rst, i_ce, i_rst_val};
        assign o_dout          = i_din;
    end else begin : g_shift
        logic [WIDTH-1:0] r_stage [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_stage[i] <= i_rst_val;
                end
            end else if (i_ce) begin
                r_stage[0] <= i_din;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_dout = r_stage[DEPTH-1];
    end

endmodule : vga_delay_line

`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster counter with sync/DE decode and delay.
// Revision    : 1.0 - initial release
// ============================================================================

module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CNT_W    = 12,
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 48,
    parameter int H_SYNC   = 112,
    parameter int H_BP     = 248,
    parameter int V_ACTIVE = 1024,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 38,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int PIX_LAT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             de,
    output logic             hs,
    output logic             vs,
    output logic             frame_start,
    output logic             line_start,
    output logic             hs_d,
    output logic             vs_d,
    output logic             de_d
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(c_h_total - 1);
    localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(c_v_total - 1);
    localparam logic [CNT_W-1:0] c_h_act    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_act    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_hs_beg   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_hs_end   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_vs_beg   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_vs_end   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam vga_sync_t c_sync_idle = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0};

    // Non-zero back porch keeps the sync end strictly inside the counter range.
    if (!cnt_fits(c_h_total, CNT_W)) begin : g_chk_h_total
        $error("vga_timing_gen: H_TOTAL %0d exceeds 2**CNT_W", c_h_total);
    end
    if (!cnt_fits(c_v_total, CNT_W)) begin : g_chk_v_total
        $error("vga_timing_gen: V_TOTAL %0d exceeds 2**CNT_W", c_v_total);
    end
    if ((H_BP < 1) || (V_BP < 1)) begin : g_chk_bp
        $error("vga_timing_gen: back porches must be at least 1");
    end
    if ((PIX_LAT < 0) || (PIX_LAT > MAX_PIX_LAT)) begin : g_chk_lat
        $error("vga_timing_gen: PIX_LAT %0d out of range", PIX_LAT);
    end

    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    vga_sync_t        r_sync;
    logic             r_frame_start;
    logic             r_line_start;

    logic [CNT_W-1:0] w_x_nxt;
    logic [CNT_W-1:0] w_y_nxt;
    logic             w_x_wrap;
    logic             w_y_wrap;
    vga_sync_t        w_sync_nxt;
    vga_sync_t        w_sync_d;

    // Decode is done on the next position so every registered flag lands with x/y.
    always_comb begin
        w_x_wrap = (r_x == c_h_last);
        w_y_wrap = (r_y == c_v_last);
        w_x_nxt  = w_x_wrap ? '0 : r_x + 1'b1;
        w_y_nxt  = r_y;
        if (w_x_wrap) begin
            w_y_nxt = w_y_wrap ? '0 : r_y + 1'b1;
        end

        w_sync_nxt.de = (w_x_nxt < c_h_act) && (w_y_nxt < c_v_act);
        w_sync_nxt.hs = ((w_x_nxt >= c_hs_beg) && (w_x_nxt < c_hs_end)) ? HS_POL : ~HS_POL;
        w_sync_nxt.vs = ((w_y_nxt >= c_vs_beg) && (w_y_nxt < c_vs_end)) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x           <= c_h_last;
            r_y           <= c_v_last;
            r_sync        <= c_sync_idle;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else if (pix_ce) begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_sync        <= w_sync_nxt;
            r_line_start  <= (w_x_nxt == '0);
            r_frame_start <= (w_x_nxt == '0) && (w_y_nxt == '0);
        end
    end

    vga_delay_line #(
        .DEPTH (PIX_LAT),
        .WIDTH ($bits(vga_sync_t))
    ) u_sync_dly (
        .clk       (clk),
        .rst       (rst),
        .i_ce      (pix_ce),
        .i_rst_val (c_sync_idle),
        .i_din     (r_sync),
        .o_dout    (w_sync_d)
    );

    assign x           = r_x;
    assign y           = r_y;
    assign de          = r_sync.de;
    assign hs          = r_sync.hs;
    assign vs          = r_sync.vs;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;
    assign hs_d        = w_sync_d.hs;
    assign vs_d        = w_sync_d.vs;
    assign de_d        = w_sync_d.de;

endmodule : vga_timing_gen

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed bench on a 14x7 raster: default, zero-latency and
//               inverted-polarity instances run side by side.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_vga_timing_gen;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic pix_ce = 1'b0;

    always #5 clk = ~clk;

    logic [7:0] a_x, a_y, z_x, z_y, n_x, n_y;
    logic a_de, a_hs, a_vs, a_fs, a_ls, a_hs_d, a_vs_d, a_de_d;
    logic z_de, z_hs, z_vs, z_fs, z_ls, z_hs_d, z_vs_d, z_de_d;
    logic n_de, n_hs, n_vs, n_fs, n_ls, n_hs_d, n_vs_d, n_de_d;

    vga_timing_gen #(
        .CNT_W(8), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(3)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(a_x), .y(a_y), .de(a_de),
        .hs(a_hs), .vs(a_vs), .frame_start(a_fs), .line_start(a_ls),
        .hs_d(a_hs_d), .vs_d(a_vs_d), .de_d(a_de_d)
    );

    vga_timing_gen #(
        .CNT_W(8), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(0)
    ) dut_lat0 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(z_x), .y(z_y), .de(z_de),
        .hs(z_hs), .vs(z_vs), .frame_start(z_fs), .line_start(z_ls),
        .hs_d(z_hs_d), .vs_d(z_vs_d), .de_d(z_de_d)
    );

    vga_timing_gen #(
        .CNT_W(8), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(3)
    ) dut_neg (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(n_x), .y(n_y), .de(n_de),
        .hs(n_hs), .vs(n_vs), .frame_start(n_fs), .line_start(n_ls),
        .hs_d(n_hs_d), .vs_d(n_vs_d), .de_d(n_de_d)
    );

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int mx        = 13;
    int my        = 6;
    int since_rst = 0;
    int fs_cyc    = 0;

    // Hand-derived decode of the 14x7 raster: de x<8,y<4; hs x=10..11; vs y=5.
    function automatic logic m_de(input int p);
        return ((p % 14) < 8) && ((p / 14) < 4);
    endfunction
    function automatic logic m_hs(input int p);
        return ((p % 14) == 10) || ((p % 14) == 11);
    endfunction
    function automatic logic m_vs(input int p);
        return (p / 14) == 5;
    endfunction
    function automatic logic [2:0] m_sync(input int p);
        return {m_hs(p), m_vs(p), m_de(p)};
    endfunction
    function automatic int cur_p();
        return my * 14 + mx;
    endfunction
    // {hs,vs,de} n pix_ce steps back; positions before reset release read as idle.
    function automatic logic [2:0] m_back(input int n);
        if (since_rst <= n) return 3'b000;
        return m_sync((cur_p() - n + 98) % 98);
    endfunction

    task automatic step();
        if (rst) begin
            mx = 13; my = 6; since_rst = 0;
        end else if (pix_ce) begin
            since_rst++;
            if (mx == 13) begin
                mx = 0;
                my = (my == 6) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({a_x, a_y, a_de} !== {8'd13, 8'd6, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state: x=%0d y=%0d de=%b, need x=13 y=6 de=0", a_x, a_y, a_de);
            end
            n_tests++;
            if ({a_hs, a_vs, a_fs, a_ls, a_hs_d, a_vs_d, a_de_d} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_flags: hs vs fs ls hs_d vs_d de_d=%b%b%b%b%b%b%b, need 0000000",
                         a_hs, a_vs, a_fs, a_ls, a_hs_d, a_vs_d, a_de_d);
            end
        end
        rst = 1'b0;
        step();
        fs_cyc = cyc;
        n_tests++;
        if ({a_x, a_y, a_de, a_fs, a_ls} !== {8'd0, 8'd0, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release: x=%0d y=%0d de=%b fs=%b ls=%b, need 0 0 1 1 1",
                     a_x, a_y, a_de, a_fs, a_ls);
        end
    endtask

    task automatic test_line();
        int last_ls = cyc;
        pix_ce = 1'b1;
        for (int i = 0; i < 28; i++) begin
            step();
            n_tests++;
            if ({a_x, a_y} !== {8'(mx), 8'(my)}) begin
                n_fail++;
                $display("FAIL line_pos: x=%0d y=%0d, need x=%0d y=%0d", a_x, a_y, mx, my);
            end
            n_tests++;
            if ({a_hs, a_de, a_ls} !== {m_hs(cur_p()), m_de(cur_p()), (mx == 0)}) begin
                n_fail++;
                $display("FAIL line_decode at x=%0d y=%0d: hs de ls=%b%b%b, need %b%b%b", mx, my,
                         a_hs, a_de, a_ls, m_hs(cur_p()), m_de(cur_p()), (mx == 0));
            end
            if (a_ls) begin
                n_tests++;
                if (cyc - last_ls != 14) begin
                    n_fail++;
                    $display("FAIL line_period: got %0d cycles, need 14", cyc - last_ls);
                end
                last_ls = cyc;
            end
        end
    endtask

    task automatic test_frame();
        bit found = 1'b0;
        pix_ce = 1'b1;
        for (int i = 0; i < 120 && !found; i++) begin
            step();
            n_tests++;
            if ({a_vs, a_de} !== {m_vs(cur_p()), m_de(cur_p())}) begin
                n_fail++;
                $display("FAIL frame_decode at x=%0d y=%0d: vs de=%b%b, need %b%b", mx, my,
                         a_vs, a_de, m_vs(cur_p()), m_de(cur_p()));
            end
            if (a_fs) begin
                found = 1'b1;
                n_tests++;
                if (cyc - fs_cyc != 98 || mx != 0 || my != 0) begin
                    n_fail++;
                    $display("FAIL frame_period: got %0d cycles at x=%0d y=%0d, need 98 at 0 0",
                             cyc - fs_cyc, mx, my);
                end
            end
        end
        if (!found) begin
            n_tests++; n_fail++;
            $display("FAIL frame_start_timeout: no frame_start within 120 cycles, need one");
        end
    endtask

    task automatic test_ce_toggle();
        int  rises = 0;
        int  first = 0;
        logic prev = a_fs;
        for (int i = 0; i < 500 && rises < 2; i++) begin
            pix_ce = (i % 2 == 0);
            step();
            n_tests++;
            if ({a_x, a_y, a_de, a_hs} !== {8'(mx), 8'(my), m_de(cur_p()), m_hs(cur_p())}) begin
                n_fail++;
                $display("FAIL ce_hold: x=%0d y=%0d de=%b hs=%b, need x=%0d y=%0d de=%b hs=%b",
                         a_x, a_y, a_de, a_hs, mx, my, m_de(cur_p()), m_hs(cur_p()));
            end
            if (a_fs && !prev) begin
                rises++;
                if (rises == 1) begin
                    first = cyc;
                end else begin
                    n_tests++;
                    if (cyc - first != 196) begin
                        n_fail++;
                        $display("FAIL ce_frame_period: got %0d clocks, need 196", cyc - first);
                    end
                end
            end
            prev = a_fs;
        end
        if (rises < 2) begin
            n_tests++; n_fail++;
            $display("FAIL ce_frame_timeout: saw %0d frame_start rises, need 2", rises);
        end
        pix_ce = 1'b1;
    endtask

    task automatic test_delay();
        for (int i = 0; i < 40; i++) begin
            pix_ce = (i % 5 != 4);
            step();
            n_tests++;
            if ({a_hs_d, a_vs_d, a_de_d} !== m_back(3)) begin
                n_fail++;
                $display("FAIL delay3 at x=%0d y=%0d: hs_d vs_d de_d=%b%b%b, need %b", mx, my,
                         a_hs_d, a_vs_d, a_de_d, m_back(3));
            end
            n_tests++;
            if ({z_hs_d, z_vs_d, z_de_d, z_x} !== {m_sync(cur_p()), 8'(mx)}) begin
                n_fail++;
                $display("FAIL delay0 at x=%0d y=%0d: hs_d vs_d de_d=%b%b%b x=%0d, need %b x=%0d",
                         mx, my, z_hs_d, z_vs_d, z_de_d, z_x, m_sync(cur_p()), mx);
            end
        end
        pix_ce = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        pix_ce = 1'b1;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            hit = (mx == 5) && (my == 2);
        end
        n_tests++;
        if (!hit || {a_x, a_y} !== {8'd5, 8'd2}) begin
            n_fail++;
            $display("FAIL mid_reach: x=%0d y=%0d, need x=5 y=2", a_x, a_y);
        end
        rst = 1'b1;
        step();
        n_tests++;
        if ({a_x, a_y, a_de, a_de_d, a_hs_d, a_vs_d, a_fs, a_ls} !== {8'd13, 8'd6, 6'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: x=%0d y=%0d de=%b de_d=%b hs_d=%b vs_d=%b fs=%b ls=%b, need 13 6 000000",
                     a_x, a_y, a_de, a_de_d, a_hs_d, a_vs_d, a_fs, a_ls);
        end
        n_tests++;
        if ({n_hs, n_vs, n_hs_d, n_vs_d, n_de_d} !== 5'b11110) begin
            n_fail++;
            $display("FAIL mid_reset_neg: hs vs hs_d vs_d de_d=%b%b%b%b%b, need 11110",
                     n_hs, n_vs, n_hs_d, n_vs_d, n_de_d);
        end
        rst = 1'b0;
        step();
        n_tests++;
        if ({a_x, a_y, a_fs, a_de_d} !== {8'd0, 8'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_release: x=%0d y=%0d fs=%b de_d=%b, need 0 0 1 0", a_x, a_y, a_fs, a_de_d);
        end
    endtask

    task automatic test_polarity();
        logic [2:0] bk;
        pix_ce = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            bk = m_back(3);
            n_tests++;
            if ({n_x, n_y, n_hs, n_vs, n_de} !== {8'(mx), 8'(my), ~m_hs(cur_p()), ~m_vs(cur_p()), m_de(cur_p())}) begin
                n_fail++;
                $display("FAIL neg_pol at x=%0d y=%0d: x=%0d y=%0d hs vs de=%b%b%b, need %b%b%b",
                         mx, my, n_x, n_y, n_hs, n_vs, n_de, ~m_hs(cur_p()), ~m_vs(cur_p()), m_de(cur_p()));
            end
            n_tests++;
            if ({n_hs_d, n_vs_d, n_de_d, a_hs} !== {~bk[2], ~bk[1], bk[0], m_hs(cur_p())}) begin
                n_fail++;
                $display("FAIL neg_pol_delay at x=%0d y=%0d: hs_d vs_d de_d=%b%b%b pos_hs=%b, need %b%b%b %b",
                         mx, my, n_hs_d, n_vs_d, n_de_d, a_hs, ~bk[2], ~bk[1], bk[0], m_hs(cur_p()));
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_ce_toggle();
        test_delay();
        test_reset_mid();
        test_polarity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_vga_timing_gen

`default_nettype wire
